// File: rtl/result_buffer_pkd_pkg.sv
// Shared constants and types for the packed result buffer.
// Defaults match the FP16, four-lane, 256-word configuration.
package result_buffer_pkd_pkg;

  localparam int unsigned result_elem_w_gp    = 16;
  localparam int unsigned result_pack_gp      = 4;
  localparam int unsigned result_buf_depth_gp = 256;

  typedef logic [result_elem_w_gp*result_pack_gp-1:0] result_word_t;
  typedef logic [result_pack_gp-1:0]                  result_keep_t;

  // Lane index width, kept at least one bit so PACK=1 still has a legal vector.
  function automatic int unsigned lane_idx_w(input int unsigned pack);
    return (pack > 1) ? $clog2(pack) : 1;
  endfunction

endpackage

// File: rtl/result_pack_stage.sv
// Lane accumulator: gathers elements into one wide word and raises a push
// when the word is complete or a flush closes it early.
module result_pack_stage
  import result_buffer_pkd_pkg::*;
#(
  parameter int unsigned DATA_W = result_elem_w_gp,
  parameter int unsigned PACK   = result_pack_gp
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_wr_en,    // already qualified by !full
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_wr_last,  // already qualified by !full
  output logic                     o_push,
  output logic [DATA_W*PACK-1:0]   o_push_data,
  output logic [PACK-1:0]          o_push_keep
);

  localparam int unsigned LANE_W = lane_idx_w(PACK);

  logic [LANE_W-1:0]      r_lane;
  logic [DATA_W*PACK-1:0] r_data;
  logic [PACK-1:0]        r_keep;

  logic [DATA_W*PACK-1:0] w_data;
  logic [PACK-1:0]        w_keep;
  logic                   w_lane_last;

  // Word as it would look with this cycle's element merged in.
  always_comb begin
    w_data = r_data;
    w_keep = r_keep;
    if (i_wr_en) begin
      w_data[r_lane*DATA_W +: DATA_W] = i_wr_data;
      w_keep[r_lane]                  = 1'b1;
    end
  end

  assign w_lane_last = (r_lane == LANE_W'(PACK - 1));
  assign o_push      = (i_wr_en && w_lane_last) || (i_wr_last && (|w_keep));
  assign o_push_data = w_data;
  assign o_push_keep = w_keep;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lane <= '0;
      r_data <= '0;
      r_keep <= '0;
    end else if (o_push) begin
      r_lane <= '0;
      r_data <= '0;
      r_keep <= '0;
    end else if (i_wr_en) begin
      r_lane <= r_lane + 1'b1;
      r_data <= w_data;
      r_keep <= w_keep;
    end
  end

endmodule

// File: rtl/result_buffer_pkd.sv
// Packed result buffer: pack stage feeding a block-RAM FIFO with a
// first-word-fall-through output register, count, almost-full and error flags.
module result_buffer_pkd
  import result_buffer_pkd_pkg::*;
#(
  parameter int unsigned DATA_W = result_elem_w_gp,
  parameter int unsigned PACK   = result_pack_gp,
  parameter int unsigned DEPTH  = result_buf_depth_gp,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [DATA_W-1:0]      i_wr_data,
  input  logic                   i_wr_en,
  input  logic                   i_wr_last,
  output logic                   o_full,
  output logic                   o_afull,
  input  logic [CNT_W-1:0]       i_afull_thresh,
  output logic [DATA_W*PACK-1:0] o_rd_data,
  output logic [PACK-1:0]        o_rd_keep,
  output logic                   o_rd_valid,
  input  logic                   i_rd_en,
  output logic [CNT_W-1:0]       o_count,
  output logic                   o_overflow,
  output logic                   o_underflow,
  input  logic                   i_clr_err
);

  localparam int unsigned WORD_W = DATA_W * PACK;
  localparam int unsigned PTR_W  = $clog2(DEPTH);

  logic [WORD_W+PACK-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_rd_valid;
  logic [WORD_W-1:0]      r_rd_data;
  logic [PACK-1:0]        r_rd_keep;
  logic                   r_afull;
  logic                   r_overflow;
  logic                   r_underflow;

  logic              w_full;
  logic              w_push;
  logic [WORD_W-1:0] w_push_data;
  logic [PACK-1:0]   w_push_keep;
  logic              w_pop;
  logic [CNT_W-1:0]  w_ram_cnt;
  logic              w_load;

  assign w_full = (r_count == CNT_W'(DEPTH));

  result_pack_stage #(
    .DATA_W (DATA_W),
    .PACK   (PACK)
  ) u_pack (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_wr_en     (i_wr_en && !w_full),
    .i_wr_data   (i_wr_data),
    .i_wr_last   (i_wr_last && !w_full),
    .o_push      (w_push),
    .o_push_data (w_push_data),
    .o_push_keep (w_push_keep)
  );

  // Words still in RAM exclude the one already staged in the output register.
  assign w_pop     = i_rd_en && r_rd_valid;
  assign w_ram_cnt = r_count - CNT_W'(r_rd_valid);
  assign w_load    = (!r_rd_valid || w_pop) && (w_ram_cnt != '0);

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_push_keep, w_push_data};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_keep   <= '0;
      r_afull     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      if (w_load) begin
        {r_rd_keep, r_rd_data} <= r_mem[r_rd_ptr];
        r_rd_ptr               <= r_rd_ptr + 1'b1;
        r_rd_valid             <= 1'b1;
      end else if (w_pop) begin
        r_rd_valid <= 1'b0;
      end

      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end

      r_afull <= (r_count >= i_afull_thresh);

      // A new error in the same cycle as a clear keeps the flag set.
      if (i_wr_en && w_full) begin
        r_overflow <= 1'b1;
      end else if (i_clr_err) begin
        r_overflow <= 1'b0;
      end

      if (i_rd_en && !r_rd_valid) begin
        r_underflow <= 1'b1;
      end else if (i_clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign o_full      = w_full;
  assign o_afull     = r_afull;
  assign o_rd_data   = r_rd_data;
  assign o_rd_keep   = r_rd_keep;
  assign o_rd_valid  = r_rd_valid;
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

`ifndef SYNTHESIS
  a_no_cnt_ovf : assert property (@(posedge i_clk) disable iff (i_reset)
    !(w_push && !w_pop && w_full));
  a_no_cnt_unf : assert property (@(posedge i_clk) disable iff (i_reset)
    !(w_pop && !w_push && (r_count == '0)));
  a_keep_nz : assert property (@(posedge i_clk) disable iff (i_reset)
    r_rd_valid |-> (r_rd_keep != '0));
`endif

endmodule

// File: tb/tb_result_buffer_pkd.sv
// Randomised scoreboard bench for result_buffer_pkd against an element-queue
// reference model of packing, occupancy, read latency and error flags.
module tb_result_buffer_pkd;
  import result_buffer_pkd_pkg::*;

  localparam int unsigned DW = result_elem_w_gp;
  localparam int unsigned PK = result_pack_gp;
  localparam int unsigned DP = result_buf_depth_gp;
  localparam int unsigned CW = $clog2(DP) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [DW-1:0]      wr_data;
  logic               wr_en;
  logic               wr_last;
  logic               full;
  logic               afull;
  logic [CW-1:0]      thresh;
  logic [DW*PK-1:0]   rd_data;
  logic [PK-1:0]      rd_keep;
  logic               rd_valid;
  logic               rd_en;
  logic [CW-1:0]      count;
  logic               overflow;
  logic               underflow;
  logic               clr_err;

  result_buffer_pkd dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_wr_data      (wr_data),
    .i_wr_en        (wr_en),
    .i_wr_last      (wr_last),
    .o_full         (full),
    .o_afull        (afull),
    .i_afull_thresh (thresh),
    .o_rd_data      (rd_data),
    .o_rd_keep      (rd_keep),
    .o_rd_valid     (rd_valid),
    .i_rd_en        (rd_en),
    .o_count        (count),
    .o_overflow     (overflow),
    .o_underflow    (underflow),
    .i_clr_err      (clr_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: elements waiting to be packed, and finished words with
  // the cycle they were pushed (head is visible two cycles after its push).
  typedef struct {
    logic [63:0] data;
    logic [PK-1:0] keep;
    int stamp;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] m_elems[$];
  int            m_count;
  bit            m_ovf, m_unf, m_afull;
  int            m_cyc;
  bit            m_live;
  bit            m_after_reset;

  function automatic word_t make_word(input int stamp);
    word_t w;
    w.data  = '0;
    w.keep  = '0;
    w.stamp = stamp;
    foreach (m_elems[i]) begin
      w.data[i*DW +: DW] = m_elems[i];
      w.keep[i]          = 1'b1;
    end
    return w;
  endfunction

  // Model step: compare current outputs, then advance across the next edge.
  always @(negedge clk) begin
    bit m_valid, m_full, push, pop;
    m_valid = (exp_q.size() > 0) && (exp_q[0].stamp + 2 <= m_cyc);
    if (m_live) begin
      check("count", 64'(count), 64'(m_count));
      check("full", 64'(full), 64'(m_count == DP));
      check("afull", 64'(afull), 64'(m_afull));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("underflow", 64'(underflow), 64'(m_unf));
      check("rd_valid", 64'(rd_valid), 64'(m_valid));
      if (m_valid) begin
        check("head_data", 64'(rd_data), exp_q[0].data);
        check("head_keep", 64'(rd_keep), 64'(exp_q[0].keep));
      end
      if (m_after_reset) begin
        check("rst_data", 64'(rd_data), 64'd0);
        check("rst_keep", 64'(rd_keep), 64'd0);
      end
    end
    if (rst) begin
      exp_q.delete();
      m_elems.delete();
      m_count = 0;
      m_ovf = 0;
      m_unf = 0;
      m_afull = 0;
      m_live = 1;
      m_after_reset = 1;
    end else if (m_live) begin
      m_full = (m_count == DP);
      push = 0;
      pop = m_valid && rd_en;
      if (wr_en && !m_full) m_elems.push_back(wr_data);
      if (!m_full && ((m_elems.size() == PK) || (wr_last && m_elems.size() > 0))) begin
        exp_q.push_back(make_word(m_cyc));
        m_elems.delete();
        push = 1;
      end
      m_afull = (m_count >= int'(thresh));
      m_count = m_count + int'(push) - int'(pop);
      if (wr_en && m_full) m_ovf = 1;
      else if (clr_err) m_ovf = 0;
      if (rd_en && !m_valid) m_unf = 1;
      else if (clr_err) m_unf = 0;
      m_after_reset = 0;
    end
    m_cyc++;
  end

  // Monitor: on each completed handshake, pop the scoreboard and compare.
  always @(negedge clk) begin
    #2;
    if (m_live && !rst && rd_valid && rd_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_empty: got word %0h, expected no word (t=%0t)", rd_data, $time);
      end else begin
        check("pop_data", 64'(rd_data), exp_q[0].data);
        check("pop_keep", 64'(rd_keep), 64'(exp_q[0].keep));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input bit we, input logic [DW-1:0] d, input bit last, input bit re);
    wr_en   = we;
    wr_data = d;
    wr_last = last;
    rd_en   = re;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    int written;
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; wr_last = 1'b0; rd_en = 1'b0;
    clr_err = 1'b0; thresh = CW'(192);
    m_cyc = 0; m_live = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Eight elements -> two full words.
    for (int i = 0; i < 8; i++) step(1'b1, DW'(16'h1000 + i), 1'b0, 1'b0);
    idle(3);
    drain(2);

    // Partial word flushed by a lone last, then a no-op last.
    for (int i = 0; i < 3; i++) step(1'b1, DW'(16'h2000 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(3);
    drain(1);
    idle(2);

    // Fill to capacity, drop a write during a pop, then four fresh elements.
    for (int i = 0; i < PK * DP; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    idle(1);
    step(1'b1, DW'(16'hdead), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, DW'(16'h3000 + i), 1'b0, 1'b0);
    idle(2);
    drain(DP + 4);
    idle(2);

    // Underflow, clear, and clear racing a new underflow.
    clr_err = 1'b1; idle(1); clr_err = 1'b0;
    drain(1);
    idle(1);
    clr_err = 1'b1; idle(1); clr_err = 1'b0;
    idle(1);
    drain(1);
    clr_err = 1'b1; drain(1); clr_err = 1'b0;
    idle(1);
    clr_err = 1'b1; idle(1); clr_err = 1'b0;

    // Streaming with random pops and a reset pulse midway.
    written = 0;
    while (written < 1000) begin
      if (written == 500 && !rst) begin
        rst = 1'b1;
        step(1'b1, DW'($urandom), 1'b0, 1'b1);
        rst = 1'b0;
        written++;
      end else begin
        bit we;
        we = ($urandom_range(0, 9) < 8);
        step(we, DW'($urandom), 1'b0, ($urandom_range(0, 9) < 7));
        if (we) written++;
      end
    end
    drain(40);

    // Random flushes mixed with writes and pops.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1));
    step(1'b0, '0, 1'b1, 1'b0);
    idle(2);
    drain(DP + 8);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
